wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter width, default 32: word width of the shared adder slice.
REQ-002 SHALL have parameter words, default 4: number of words per operand; legal range is 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-007 SHALL have ports a and b, input, width*words bits each: the wide operands.
REQ-008 SHALL have port cin, input, 1 bit: the carry into word 0.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is held on s and cout.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port s, output, width*words bits: the wide sum.
REQ-012 SHALL have port cout, output, 1 bit: the carry out of the top word.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-014 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-015 SHALL assert in_ready only in IDLE; an input transfer is the edge where in_valid and in_ready are both high.
REQ-016 SHALL, on an input transfer, register a, b and cin into the operand and carry registers, clear the word index to 0 and go to RUN.
REQ-017 SHALL, in RUN, on each edge, add word idx of a and b plus the carry register through one width-bit adder slice, write the sum into word idx of s, load the carry register with the slice carry out, and increment idx.
REQ-018 SHALL, in RUN when idx = words-1, complete that word, load cout with the final carry and go to DONE on the same edge.
REQ-019 SHALL make out_valid high beginning exactly words edges after the accepting edge, giving a fixed latency of words cycles.
REQ-020 SHALL assert out_valid only in DONE, and SHALL hold s and cout stable while out_valid is high and out_ready is low.
REQ-021 SHALL, in DONE, go to IDLE on the edge where out_ready is high.
REQ-022 SHALL NOT accept new input in the same cycle as the output transfer, so the minimum issue interval is words+2 cycles.
REQ-023 SHALL ignore in_valid outside IDLE and SHALL NOT sample a, b or cin after the accepting edge.
REQ-024 SHALL compute the result modulo 2^(width*words); the carry out of the top word appears only on cout.
REQ-025 SHALL keep s and cout at their last values in IDLE; they are valid only while out_valid is high.
REQ-026 SHALL make the index counter ceil(log2(words)) bits wide; the index SHALL NOT wrap inside RUN.

Reset
REQ-027 SHALL, while rst is high at an edge, set the state to IDLE, idx to 0, the carry register to 0, s to 0, cout to 0, out_valid to 0 and busy to 0; in_ready SHALL be 0 during the reset cycle.
REQ-028 SHALL abandon any operation in progress when rst is asserted in RUN or DONE; no out_valid pulse SHALL follow.
REQ-029 SHALL have rst take priority over in_valid and out_ready in the same cycle.

Structure
REQ-030 SHALL take the state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) and the default width and words values from a shared package, wide_add_pkg.
REQ-031 SHALL instantiate exactly one carryLHN with width = width as the adder slice; no second adder SHALL exist.
REQ-032 SHALL use only registered outputs, except in_ready, which is decoded from the state register.

Verification
REQ-033 SHALL cover the single add: width=32, words=4, a=0x0000_0001_0000_0002_0000_0003_0000_0004, b=0x0000_0005_0000_0006_0000_0007_0000_0008, cin=0 -> s=0x0000_0006_0000_0008_0000_000A_0000_000C, cout=0, out_valid 4 edges after acceptance.
REQ-034 SHALL cover full carry ripple: a=all ones, b=0, cin=1 -> s=0, cout=1.
REQ-035 SHALL cover backpressure: out_ready held low for 5 cycles -> s, cout and out_valid stable, in_ready 0 throughout, in_valid pulses ignored.
REQ-036 SHALL cover reset mid-RUN: rst for 1 cycle at idx=2 -> next cycle IDLE, in_ready=1, s=0; out_valid never asserted.
REQ-037 SHALL cover back-to-back transfers: in_valid held high and out_ready held high for two operand sets -> the second is accepted exactly words+2 cycles after the first and both results are correct.
REQ-038 SHALL cover random regression: 1000 random a, b and cin -> {cout,s} equals a+b+cin under a reference model.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared definitions for the word-serial wide adder: default geometry and FSM encoding.
package wide_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_seq_carrylhn.sv
// Single width-bit adder slice with carry in and carry out.
module carryLHN #(
  parameter int width = 32
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             ci,
  output logic [width-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, ci};

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder: one adder slice is reused for each word, low word first,
// giving a fixed latency of words cycles from acceptance to out_valid.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int words = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid does not wait for ready, and s/cout hold steady while out_valid is high.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [width*words-1:0] a,
  input  logic [width*words-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width*words-1:0] s,
  output logic                   cout,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int IW = $clog2(words);

  state_t                 state, state_n;
  logic [IW-1:0]          idx;
  logic                   carry;
  logic [width*words-1:0] opa, opb;
  logic [width-1:0]       slice_a, slice_b, slice_s;
  logic                   slice_co;
  logic                   last;
  logic                   accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last      = (idx == IW'(words - 1));
  assign dbg_state = state;

  assign slice_a = opa[idx*width +: width];
  assign slice_b = opb[idx*width +: width];

  carryLHN #(.width(width)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operands are captured only on acceptance and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= a;
      opb <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          s[idx*width +: width] <= slice_s;
          carry                 <= slice_co;
          if (last) begin
            cout      <= slice_co;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random checks of wide_add_seq against an arithmetic reference model.
module tb_wide_add_seq;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int W     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         busy;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  int           chk_count = 0;
  int           err_count = 0;
  int           cyc = 0;

  wide_add_seq #(.width(WIDTH), .words(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    chk_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < WORDS; i++) r[i*WIDTH +: WIDTH] = $urandom();
    return r;
  endfunction

  // driver: offer one operand set, push its reference result, then scramble the inputs
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    check("in_ready_before_send", in_ready, 1);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    exp_q.push_back({1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc});
    step();
    in_valid = 1'b0;
    a = rand_wide();
    b = rand_wide();
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  // scoreboard: compare the held result with the oldest expectation, then take it
  task automatic consume();
    logic [W:0] e;
    check("queue_nonempty", exp_q.size() > 0, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("sum", {cout, s}, e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_cleared", out_valid, 0);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    logic [W:0] held;
    logic saw_ov;
    logic acc_next;

    // reset
    rst = 1'b1;
    step();
    check("in_ready_in_reset", in_ready, 0);
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    #1;
    check("in_ready_idle", in_ready, 1);

    // single add with latency check
    send(128'h0000_0001_0000_0002_0000_0003_0000_0004,
         128'h0000_0005_0000_0006_0000_0007_0000_0008, 1'b0);
    check("busy_run", busy, 1);
    check("in_ready_run", in_ready, 0);
    wait_out(lat);
    check("latency_single", lat, WORDS);
    check("single_value", {cout, s}, {1'b0, 128'h0000_0006_0000_0008_0000_000A_0000_000C});
    consume();

    // full carry ripple
    send('1, '0, 1'b1);
    wait_out(lat);
    check("ripple_value", {cout, s}, {1'b1, {W{1'b0}}});
    consume();

    // backpressure with ignored in_valid pulses
    send(rand_wide(), rand_wide(), 1'b1);
    wait_out(lat);
    held = {cout, s};
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {cout, s}, held);
    end
    in_valid = 1'b0;
    consume();

    // reset in the middle of RUN at idx=2
    send(rand_wide(), rand_wide(), 1'b0);
    step();
    step();
    check("mid_run_state", dbg_state, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_s", s, 0);
    check("mid_rst_busy", busy, 0);
    saw_ov = 1'b0;
    for (int k = 0; k < 10; k++) begin
      saw_ov |= out_valid;
      step();
    end
    check("mid_rst_no_out_valid", saw_ov, 0);

    // back-to-back with in_valid and out_ready held high
    a = rand_wide();
    b = rand_wide();
    cin = 1'b1;
    check("b2b_in_ready", in_ready, 1);
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    t1 = cyc;
    t2 = -1;
    a = rand_wide();
    b = rand_wide();
    cin = 1'b0;
    for (int k = 0; k < 20 && t2 < 0; k++) begin
      acc_next = in_ready && in_valid;
      if (out_valid) check("b2b_first_sum", {cout, s}, exp_q.pop_front());
      step();
      if (acc_next) begin
        t2 = cyc;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        in_valid = 1'b0;
      end
    end
    check("b2b_interval", t2 - t1, WORDS + 2);
    wait_out(lat);
    check("b2b_latency", lat, WORDS);
    check("b2b_second_sum", {cout, s}, exp_q.pop_front());
    step();
    out_ready = 1'b0;
    check("b2b_done", out_valid, 0);

    // random regression
    for (int n = 0; n < 1000; n++) begin
      send(rand_wide(), rand_wide(), 1'($urandom_range(0, 1)));
      wait_out(lat);
      repeat ($urandom_range(0, 2)) step();
      consume();
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_count, err_count);
    $finish;
  end

endmodule
